// File: rtl/pipe_share_arbiter_pkg.sv
// Shared types and helpers for pipe_share_arbiter.
// Owner tags are sized for the largest supported requester count (8), so every
// NREQ in 2..8 fits in the same tag type.
package pipe_share_pkg;

    localparam int IW       = 10;
    localparam int OW       = 16;
    localparam int MAX_NREQ = 8;
    localparam int OWNER_W  = $clog2(MAX_NREQ);

    typedef logic [IW-1:0] in_word_t;
    typedef logic [OW-1:0] out_word_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

    // Round-robin search starting at last+1 and wrapping. Bits of mask at or
    // above NREQ are zero, so wrapping modulo MAX_NREQ visits requesters in the
    // same order as wrapping modulo NREQ. Returns last when mask is empty.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] mask,
                                                   input logic [OWNER_W-1:0]  last);
        logic [OWNER_W-1:0] idx;
        rr_pick = last;
        // Descending scan so the nearest candidate after last is written last.
        for (int unsigned k = MAX_NREQ; k > 0; k--) begin
            idx = last + OWNER_W'(k);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/pipe_share_arbiter_rsp_fifo.sv
// Per-requester response FIFO: pointer based, DEPTH a power of two, no
// fall-through (a push into an empty FIFO is visible the next cycle).
// Overflow is prevented upstream by the credit scheme.
module rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int OW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [OW-1:0] push_data,
    input  logic          pop,
    output logic          empty,
    output logic [OW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [OW-1:0] mem [DEPTH];

    // Read/write pointers with an extra wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one non-stallable pipelined datapath between NREQ
// requesters, with per-requester credits guarding the response FIFOs.
// Optional statistics outputs are enabled with PIPE_SHARE_ARBITER_STATS_EN.
module pipe_share_arbiter
    import pipe_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*IW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*OW-1:0] rsp_data,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [IW-1:0]      dp_in,
    input  logic [OW-1:0]      dp_out
`ifdef PIPE_SHARE_ARBITER_STATS_EN
    ,
    output logic [31:0]        issue_count,
    output logic [31:0]        bubble_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant_oh;
    logic [NREQ-1:0]     pop;
    logic [NREQ-1:0]     push;
    logic [NREQ-1:0]     empty;
    logic [MAX_NREQ-1:0] mask;
    logic                any_grant;
    logic [OWNER_W-1:0]  grant_idx;
    logic [OWNER_W-1:0]  last;
    in_word_t            grant_word;
    tag_t                tag_pipe [LATENCY+1];
    logic [CW-1:0]       credit [NREQ];

    // Eligibility, round-robin grant and selection of the granted word.
    always_comb begin
        mask       = '0;
        grant_oh   = '0;
        grant_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (credit[i] != '0);
        end
        mask[NREQ-1:0] = eligible;
        any_grant      = |eligible;
        grant_idx      = rr_pick(mask, last);
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_oh[i] = any_grant && (grant_idx == OWNER_W'(i));
            if (grant_oh[i]) grant_word = req_data[i*IW +: IW];
        end
    end

    assign req_ready = grant_oh;

    // FIFO pop requests and result steering from the last tag stage.
    always_comb begin
        pop  = '0;
        push = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pop[i]  = !empty[i] && rsp_ready[i];
            push[i] = tag_pipe[LATENCY].valid && (tag_pipe[LATENCY].owner == OWNER_W'(i));
        end
    end

    assign rsp_valid = ~empty;

    // Datapath input register, round-robin pointer and tag shift register.
    // tag_pipe[0] sits alongside dp_in; tag_pipe[LATENCY] sits alongside dp_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_in <= '0;
            last  <= OWNER_W'(NREQ - 1);
            for (int unsigned j = 0; j <= LATENCY; j++) begin
                tag_pipe[j] <= '0;
            end
        end else begin
            dp_in                <= any_grant ? grant_word : '0;
            tag_pipe[0].valid    <= any_grant;
            tag_pipe[0].owner    <= any_grant ? grant_idx : '0;
            if (any_grant) last  <= grant_idx;
            for (int unsigned j = 1; j <= LATENCY; j++) begin
                tag_pipe[j] <= tag_pipe[j-1];
            end
        end
    end

    // Credits: a grant consumes one, a pop returns one; both together cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                credit[i] <= CW'(DEPTH);
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                case ({grant_oh[i], pop[i]})
                    2'b10:   credit[i] <= credit[i] - CW'(1);
                    2'b01:   credit[i] <= credit[i] + CW'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        rsp_fifo #(
            .DEPTH (DEPTH),
            .OW    (OW)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (dp_out),
            .pop       (pop[i]),
            .empty     (empty[i]),
            .head      (rsp_data[i*OW +: OW])
        );
    end

`ifdef PIPE_SHARE_ARBITER_STATS_EN
    // Saturating counters of grants and of credit-starved cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (any_grant && (issue_count != '1)) issue_count <= issue_count + 32'd1;
            if ((|req_valid) && !any_grant && (bubble_count != '1)) bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Self-checking bench for pipe_share_arbiter (NREQ=4, LATENCY=2, DEPTH=4).
// Reference model: tokens held in an in-flight queue with a due edge, response
// FIFOs as queues, credit derived from queue occupancies.
module tb_pipe_share_arbiter;

    localparam int NREQ    = 4;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*10-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ-1:0]  rsp_valid;
    logic [NREQ*16-1:0] rsp_data;
    logic [NREQ-1:0]  rsp_ready;
    logic [9:0]       dp_in;
    logic [15:0]      dp_out;
`ifdef PIPE_SHARE_ARBITER_STATS_EN
    logic [31:0]      issue_count;
    logic [31:0]      bubble_count;
`endif

    pipe_share_arbiter #(
        .NREQ    (NREQ),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .dp_in     (dp_in),
        .dp_out    (dp_out)
`ifdef PIPE_SHARE_ARBITER_STATS_EN
        ,
        .issue_count  (issue_count),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    // Datapath stand-in: two-cycle delay, zero-extended output.
    logic [9:0] d1, d2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= dp_in;
            d2 <= d1;
        end
    end
    assign dp_out = {6'h0, d2};

    typedef struct {
        int         owner;
        logic [9:0] word;
        int         due;
    } tok_t;

    tok_t        inflight[$];
    logic [15:0] mfifo [NREQ][$];
    int          m_last;
    int          m_edge;
    logic [9:0]  m_dp_in;
    int          obs_grants [NREQ];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic int m_credit(input int i);
        int c;
        c = DEPTH - mfifo[i].size();
        foreach (inflight[k]) if (inflight[k].owner == i) c--;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ*10-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[NREQ*10-1:0];
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic [NREQ-1:0] rv, input logic [NREQ*10-1:0] rd,
                        input logic [NREQ-1:0] rr);
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_valid;
        tok_t            t;
        req_valid = rv;
        req_data  = rd;
        rsp_ready = rr;
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (g < 0 && rv[idx] && m_credit(idx) > 0) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            exp_valid[i] = (mfifo[i].size() > 0);
            if (req_ready[i] && rv[i]) obs_grants[i]++;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("dp_in", 64'(dp_in), 64'(m_dp_in));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        for (int i = 0; i < NREQ; i++) begin
            if (mfifo[i].size() > 0) chk("rsp_data", 64'(rsp_data[i*16 +: 16]), 64'(mfifo[i][0]));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (mfifo[i].size() > 0 && rr[i]) void'(mfifo[i].pop_front());
        end
        while (inflight.size() > 0 && inflight[0].due == m_edge) begin
            t = inflight.pop_front();
            mfifo[t.owner].push_back({6'h0, t.word});
        end
        if (g >= 0) begin
            t.owner = g;
            t.word  = rd[g*10 +: 10];
            t.due   = m_edge + LATENCY + 1;
            inflight.push_back(t);
            m_dp_in = t.word;
            m_last  = g;
        end else begin
            m_dp_in = '0;
        end
        m_edge++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_dp_in", 64'(dp_in), 64'h0);
        inflight.delete();
        for (int i = 0; i < NREQ; i++) begin
            mfifo[i].delete();
            obs_grants[i] = 0;
        end
        m_last  = NREQ - 1;
        m_dp_in = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        m_edge    = 0;
        #2;
        do_reset();

        // Single token from requester 0.
        step(4'b0001, 40'h15, 4'b1111);
        chk("t1_dp_in", 64'(dp_in), 64'h015);
        step(4'b0000, '0, 4'b1111);
        step(4'b0000, '0, 4'b1111);
        chk("t1_rsp_valid_c3", 64'(rsp_valid), 64'h0);
        step(4'b0000, '0, 4'b1111);
        chk("t1_rsp_valid_c4", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_data", 64'(rsp_data[15:0]), 64'h0015);
        for (int i = 0; i < 3; i++) step(4'b0000, '0, 4'b1111);

        // All requesters continuously valid.
        do_reset();
        for (int i = 0; i < 16; i++) step(4'b1111, rnd_data(), 4'b1111);
        for (int i = 0; i < NREQ; i++) chk("t2_grants", 64'(obs_grants[i]), 64'd4);
        for (int i = 0; i < 6; i++) step(4'b0000, '0, 4'b1111);

        // Requester 2 exhausts its credit; requester 0 keeps being served.
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b0101, rnd_data(), 4'b1011);
        chk("t3_grants2", 64'(obs_grants[2]), 64'd4);
        step(4'b0101, rnd_data(), 4'b1111);
        step(4'b0101, rnd_data(), 4'b1011);
        chk("t3_regrant", 64'(obs_grants[2]), 64'd5);
        for (int i = 0; i < 8; i++) step(4'b0000, '0, 4'b1111);

        // Same-cycle grant and pop on requester 1 at credit 1.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0010, rnd_data(), 4'b1101);
        for (int i = 0; i < 4; i++) step(4'b0000, '0, 4'b1101);
        step(4'b0010, rnd_data(), 4'b1111);
        step(4'b0010, rnd_data(), 4'b1101);
        chk("t4_grants1", 64'(obs_grants[1]), 64'd5);
        step(4'b0010, rnd_data(), 4'b1101);
        chk("t4_starved", 64'(obs_grants[1]), 64'd5);
        for (int i = 0; i < 8; i++) step(4'b0000, '0, 4'b1111);

        // Reset with results queued and tokens in flight.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0111, rnd_data(), 4'b0000);
        step(4'b0000, '0, 4'b0000);
        chk("t5_pre_rst_valid", 64'(rsp_valid), 64'h1);
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0000, '0, 4'b1111);
        step(4'b1111, rnd_data(), 4'b1111);
        chk("t5_first_grant", 64'(obs_grants[0]), 64'd1);
        for (int i = 0; i < 6; i++) step(4'b0000, '0, 4'b1111);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(NREQ'($urandom()), rnd_data(), NREQ'($urandom() | $urandom()));
        end
        for (int i = 0; i < 12; i++) step(4'b0000, '0, 4'b1111);

`ifdef PIPE_SHARE_ARBITER_STATS_EN
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0110, rnd_data(), 4'b1110);
        for (int i = 0; i < 7; i++) step(4'b0001, rnd_data(), 4'b1110);
        chk("stats_issue", 64'(issue_count), 64'd10);
        chk("stats_bubble", 64'(bubble_count), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
